// File: rtl/sram_burst_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_burst_arbiter_if
//
// Bundles every signal between the two burst requesters, the burst arbiter and
// the 1024x8 SRAM wrapper. Clock and reset stay outside the interface.
//
// Handshake semantics (the only flow-control rules in this block):
//   * i_ReqN is a request held high until the cycle o_AckN is seen; i_WrN,
//     i_AddrN and i_LenN must be stable while i_ReqN is high. Dropping i_ReqN
//     before o_AckN withdraws the request.
//   * o_PopN high means i_WDataN is consumed at the end of this cycle; the
//     requester presents the next word in the following cycle. No backpressure.
//   * o_RValidN high means o_RData carries a read beat for port N this cycle.
//     The sink must accept it; there is no ready.
//   * o_DoneN is a one-cycle pulse marking the end of port N's burst.
//
// Modports:
//   slave  - the arbiter's view (drives o_*, samples i_*)
//   master - the environment's view (requesters plus SRAM wrapper)
// -----------------------------------------------------------------------------
interface sram_burst_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    // Requester side
    logic              i_Req0,    i_Req1;
    logic              i_Wr0,     i_Wr1;
    logic [ADDR_W-1:0] i_Addr0,   i_Addr1;
    logic [ADDR_W-1:0] i_Len0,    i_Len1;
    logic [DATA_W-1:0] i_WData0,  i_WData1;
    logic              o_Ack0,    o_Ack1;
    logic              o_Pop0,    o_Pop1;
    logic              o_RValid0, o_RValid1;
    logic [DATA_W-1:0] o_RData;
    logic              o_Done0,   o_Done1;
    logic              o_Busy;
    // SRAM side
    logic              o_SRAM_EN_R;
    logic              o_SRAM_EN_W;
    logic [ADDR_W-1:0] o_SRAM_Addr;
    logic [DATA_W-1:0] o_SRAM_DataIn;
    logic [DATA_W-1:0] i_SRAM_DataOut;
    // Controller state for observation (0 idle, 1 burst, 2 drain)
    logic [1:0]        o_DbgState;

    modport slave (
        input  i_Req0, i_Req1, i_Wr0, i_Wr1, i_Addr0, i_Addr1,
               i_Len0, i_Len1, i_WData0, i_WData1, i_SRAM_DataOut,
        output o_Ack0, o_Ack1, o_Pop0, o_Pop1, o_RValid0, o_RValid1,
               o_RData, o_Done0, o_Done1, o_Busy,
               o_SRAM_EN_R, o_SRAM_EN_W, o_SRAM_Addr, o_SRAM_DataIn,
               o_DbgState
    );

    modport master (
        output i_Req0, i_Req1, i_Wr0, i_Wr1, i_Addr0, i_Addr1,
               i_Len0, i_Len1, i_WData0, i_WData1, i_SRAM_DataOut,
        input  o_Ack0, o_Ack1, o_Pop0, o_Pop1, o_RValid0, o_RValid1,
               o_RData, o_Done0, o_Done1, o_Busy,
               o_SRAM_EN_R, o_SRAM_EN_W, o_SRAM_Addr, o_SRAM_DataIn,
               o_DbgState
    );
endinterface

// File: rtl/sram_burst_arbiter.sv
// -----------------------------------------------------------------------------
// sram_burst_arbiter
//
// Two-port round-robin burst controller in front of a single-port SRAM.
// A granted burst runs to completion: one beat per cycle at sequential
// addresses (wrapping at 2^ADDR_W). Writes pull data from the requester's
// FIFO head via o_Pop; reads return SRAM Q with a port-tagged valid strobe.
//
// Ports:
//   CLK     - clock
//   i_RSTn  - asynchronous active-low reset; aborts any burst silently
//   bus     - sram_burst_arbiter_if.slave: requester handshakes, read return,
//             registered SRAM controls, controller state for observation
// -----------------------------------------------------------------------------
module sram_burst_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic                 CLK,
    input  logic                 i_RSTn,
    sram_burst_arbiter_if.slave  bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [1:0]        state_q,     state_d;
    logic              port_q,      port_d;      // granted port
    logic              wr_q,        wr_d;        // granted burst is a write
    logic              pref_q,      pref_d;      // port preferred on a tie
    logic [ADDR_W-1:0] addr_q,      addr_d;      // address of the next beat
    logic [ADDR_W-1:0] len_q,       len_d;
    logic [ADDR_W-1:0] cnt_q,       cnt_d;       // index of the next beat
    logic              ack0_q,      ack0_d;
    logic              ack1_q,      ack1_d;
    logic              en_r_q,      en_r_d;
    logic              en_w_q,      en_w_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0] sram_din_q,  sram_din_d;
    // Read-valid pipeline: stage 1 lines up with the beat on the SRAM pins,
    // stage 2 with the cycle its Q is available.
    logic              rv1_q,       rv1_d;
    logic              rv2_q,       rv2_d;

    logic              gnt;
    logic              pop_any;
    logic              done_any;

    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        wr_d        = wr_q;
        pref_d      = pref_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        en_r_d      = 1'b0;
        en_w_d      = 1'b0;
        sram_addr_d = sram_addr_q;
        sram_din_d  = sram_din_q;
        rv1_d       = 1'b0;
        rv2_d       = rv1_q;
        gnt         = 1'b0;
        pop_any     = 1'b0;
        done_any    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_Req0 || bus.i_Req1) begin
                    // Lone requester wins outright; a tie goes to pref_q.
                    gnt     = (bus.i_Req0 && bus.i_Req1) ? pref_q : bus.i_Req1;
                    port_d  = gnt;
                    wr_d    = gnt ? bus.i_Wr1   : bus.i_Wr0;
                    addr_d  = gnt ? bus.i_Addr1 : bus.i_Addr0;
                    len_d   = gnt ? bus.i_Len1  : bus.i_Len0;
                    cnt_d   = '0;
                    pref_d  = ~gnt;
                    ack0_d  = ~gnt;
                    ack1_d  = gnt;
                    state_d = ST_BURST;
                end
            end

            ST_BURST: begin
                en_r_d      = 1'b1;
                en_w_d      = wr_q;
                sram_addr_d = addr_q;
                addr_d      = addr_q + ADDR_ONE;   // natural wrap at 2^ADDR_W
                cnt_d       = cnt_q + ADDR_ONE;
                if (wr_q) begin
                    sram_din_d = port_q ? bus.i_WData1 : bus.i_WData0;
                    pop_any    = 1'b1;
                end else begin
                    rv1_d = 1'b1;
                end
                if (cnt_q == len_q) begin
                    if (wr_q) begin
                        done_any = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                // The last read beat is the one in stage 2 with nothing behind it.
                if (rv2_q && !rv1_q) begin
                    done_any = 1'b1;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q     <= ST_IDLE;
            port_q      <= 1'b0;
            wr_q        <= 1'b0;
            pref_q      <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            en_r_q      <= 1'b0;
            en_w_q      <= 1'b0;
            sram_addr_q <= '0;
            sram_din_q  <= '0;
            rv1_q       <= 1'b0;
            rv2_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            wr_q        <= wr_d;
            pref_q      <= pref_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            en_r_q      <= en_r_d;
            en_w_q      <= en_w_d;
            sram_addr_q <= sram_addr_d;
            sram_din_q  <= sram_din_d;
            rv1_q       <= rv1_d;
            rv2_q       <= rv2_d;
        end
    end

    // port_q stays valid through DRAIN because no new grant happens until IDLE,
    // so it can tag the read-return strobe directly.
    assign bus.o_Ack0        = ack0_q;
    assign bus.o_Ack1        = ack1_q;
    assign bus.o_Pop0        = pop_any & ~port_q;
    assign bus.o_Pop1        = pop_any &  port_q;
    assign bus.o_Done0       = done_any & ~port_q;
    assign bus.o_Done1       = done_any &  port_q;
    assign bus.o_RValid0     = rv2_q & ~port_q;
    assign bus.o_RValid1     = rv2_q &  port_q;
    assign bus.o_RData       = bus.i_SRAM_DataOut;
    assign bus.o_Busy        = (state_q != ST_IDLE);
    assign bus.o_SRAM_EN_R   = en_r_q;
    assign bus.o_SRAM_EN_W   = en_w_q;
    assign bus.o_SRAM_Addr   = sram_addr_q;
    assign bus.o_SRAM_DataIn = sram_din_q;
    assign bus.o_DbgState    = state_q;

endmodule

// File: tb/tb_sram_burst_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_burst_arbiter
//
// Drives sram_burst_arbiter through directed and randomized bursts against a
// behavioural SRAM, and checks every logged cycle against a transaction-level
// reference (expected memory contents, arbitration order, beat timing).
// -----------------------------------------------------------------------------
module tb_sram_burst_arbiter;
    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1024;
    localparam int LOGN  = 1200;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic i_RSTn;
    always #5 CLK = ~CLK;

    sram_burst_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_burst_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK    (CLK),
        .i_RSTn (i_RSTn),
        .bus    (bus)
    );

    // ---------------- behavioural SRAM (registered Q) ----------------
    logic [DW-1:0] sram_mem [DEPTH];
    logic [DW-1:0] sram_q;
    always @(posedge CLK) begin
        if (bus.o_SRAM_EN_R) begin
            if (bus.o_SRAM_EN_W) sram_mem[bus.o_SRAM_Addr] <= bus.o_SRAM_DataIn;
            else                 sram_q <= sram_mem[bus.o_SRAM_Addr];
        end
    end
    assign bus.i_SRAM_DataOut = sram_q;

    // ---------------- reference model state ----------------
    logic [DW-1:0] ref_mem [DEPTH];
    int            rr_pref;                 // port that wins the next tie
    int            p_en[2], p_wr[2], p_addr[2], p_len[2];
    logic [DW-1:0] wpat0 [DEPTH];
    logic [DW-1:0] wpat1 [DEPTH];
    int            wptr0, wptr1;

    // ---------------- per-cycle observation log ----------------
    logic          lg_en   [LOGN];
    logic          lg_we   [LOGN];
    logic [AW-1:0] lg_addr [LOGN];
    logic [DW-1:0] lg_din  [LOGN];
    logic [DW-1:0] lg_rdata[LOGN];
    logic [1:0]    lg_pop  [LOGN];
    logic [1:0]    lg_rv   [LOGN];
    logic [1:0]    lg_done [LOGN];
    logic [1:0]    lg_ack  [LOGN];
    logic          lg_busy [LOGN];
    int            cyc;
    int            bad_we;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] oh(input int p);
        return (p == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [DW-1:0] wp(input int p, input int i);
        return (p == 1) ? wpat1[i] : wpat0[i];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_run();
        for (int c = 0; c < LOGN; c++) begin
            lg_en[c] = 0; lg_we[c] = 0; lg_addr[c] = '0; lg_din[c] = '0;
            lg_rdata[c] = '0; lg_pop[c] = '0; lg_rv[c] = '0; lg_done[c] = '0;
            lg_ack[c] = '0; lg_busy[c] = 0;
        end
        cyc = 0; bad_we = 0; wptr0 = 0; wptr1 = 0;
        p_en[0] = 0; p_en[1] = 0;
    endtask

    task automatic set_req(input int port, input int wr, input int addr, input int len, input int base);
        for (int i = 0; i <= len; i++) begin
            logic [DW-1:0] v;
            v = (base >= 0) ? DW'(base + i) : DW'($urandom_range(255, 0));
            if (port == 1) wpat1[i] = v; else wpat0[i] = v;
        end
        p_en[port] = 1; p_wr[port] = wr; p_addr[port] = addr; p_len[port] = len;
        if (port == 0) begin
            bus.i_Wr0 = wr[0]; bus.i_Addr0 = AW'(addr); bus.i_Len0 = AW'(len);
            bus.i_WData0 = wpat0[0]; wptr0 = 0; bus.i_Req0 = 1'b1;
        end else begin
            bus.i_Wr1 = wr[0]; bus.i_Addr1 = AW'(addr); bus.i_Len1 = AW'(len);
            bus.i_WData1 = wpat1[0]; wptr1 = 0; bus.i_Req1 = 1'b1;
        end
    endtask

    // One cycle: refresh FIFO heads after last cycle's pops, then log outputs.
    task automatic step();
        @(negedge CLK);
        bus.i_WData0 = wpat0[wptr0 % DEPTH];
        bus.i_WData1 = wpat1[wptr1 % DEPTH];
        if (cyc < LOGN) begin
            lg_en[cyc]    = bus.o_SRAM_EN_R;
            lg_we[cyc]    = bus.o_SRAM_EN_W;
            lg_addr[cyc]  = bus.o_SRAM_Addr;
            lg_din[cyc]   = bus.o_SRAM_DataIn;
            lg_rdata[cyc] = bus.o_RData;
            lg_pop[cyc]   = {bus.o_Pop1, bus.o_Pop0};
            lg_rv[cyc]    = {bus.o_RValid1, bus.o_RValid0};
            lg_done[cyc]  = {bus.o_Done1, bus.o_Done0};
            lg_ack[cyc]   = {bus.o_Ack1, bus.o_Ack0};
            lg_busy[cyc]  = bus.o_Busy;
        end
        if (bus.o_SRAM_EN_W && !bus.o_SRAM_EN_R) bad_we++;
        if (bus.o_Pop0) wptr0++;
        if (bus.o_Pop1) wptr1++;
        if (bus.o_Ack0) bus.i_Req0 = 1'b0;
        if (bus.o_Ack1) bus.i_Req1 = 1'b0;
        cyc++;
    endtask

    task automatic run_cycles(input int budget);
        int idle;
        idle = 0;
        for (int k = 0; k < budget && idle < 3; k++) begin
            step();
            if (!bus.i_Req0 && !bus.i_Req1 && !bus.o_Busy) idle++;
            else idle = 0;
        end
        chk("run_completes", idle, 3);
    endtask

    task automatic check_idle_outputs();
        chk("idle_ack",    {bus.o_Ack1, bus.o_Ack0}, 0);
        chk("idle_pop",    {bus.o_Pop1, bus.o_Pop0}, 0);
        chk("idle_rvalid", {bus.o_RValid1, bus.o_RValid0}, 0);
        chk("idle_done",   {bus.o_Done1, bus.o_Done0}, 0);
        chk("idle_busy",   bus.o_Busy, 0);
        chk("idle_en",     {bus.o_SRAM_EN_R, bus.o_SRAM_EN_W}, 0);
        chk("idle_addr",   bus.o_SRAM_Addr, 0);
        chk("idle_din",    bus.o_SRAM_DataIn, 0);
        chk("idle_state",  bus.o_DbgState, 0);
    endtask

    // ---------------- scoreboard ----------------
    // A = cycle of the port's Ack. Beat i is on the SRAM pins at A+1+i, its
    // pop at A+i, its read data at A+2+i.
    task automatic check_burst(input int p, input int a_cyc);
        int wr, len, ea, c, endc;
        wr = p_wr[p]; len = p_len[p];
        for (int i = 0; i <= len; i++) begin
            ea = (p_addr[p] + i) % DEPTH;
            c  = a_cyc + 1 + i;
            chk("beat_en",   lg_en[c], 1);
            chk("beat_we",   lg_we[c], wr);
            chk("beat_addr", lg_addr[c], ea);
            if (wr != 0) begin
                chk("beat_din", lg_din[c], wp(p, i));
                chk("pop",      lg_pop[a_cyc + i], oh(p));
                ref_mem[ea] = wp(p, i);
            end else begin
                chk("rvalid", lg_rv[a_cyc + 2 + i], oh(p));
                chk("rdata",  lg_rdata[a_cyc + 2 + i], ref_mem[ea]);
            end
        end
        endc = (wr != 0) ? a_cyc + len : a_cyc + 2 + len;
        chk("done",      lg_done[endc], oh(p));
        chk("busy_last", lg_busy[endc], 1);
        chk("busy_idle", lg_busy[endc + 1], 0);
    endtask

    task automatic verify_run();
        int ackc[2], nack[2], npop[2], nrv[2], ndone[2];
        int ndual, nen, exp_en, first, second, exp_a;
        for (int p = 0; p < 2; p++) begin
            ackc[p] = -1; nack[p] = 0; npop[p] = 0; nrv[p] = 0; ndone[p] = 0;
        end
        ndual = 0; nen = 0; exp_en = 0;
        for (int c = 0; c < cyc && c < LOGN; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (lg_ack[c][p]) begin
                    if (nack[p] == 0) ackc[p] = c;
                    nack[p]++;
                end
                if (lg_pop[c][p])  npop[p]++;
                if (lg_rv[c][p])   nrv[p]++;
                if (lg_done[c][p]) ndone[p]++;
            end
            if (lg_ack[c] == 2'b11) ndual++;
            if (lg_en[c]) nen++;
        end
        chk("ack0_count", nack[0], p_en[0]);
        chk("ack1_count", nack[1], p_en[1]);
        chk("dual_ack",   ndual, 0);
        chk("we_without_en", bad_we, 0);
        for (int p = 0; p < 2; p++) begin
            if (p_en[p] != 0) exp_en += p_len[p] + 1;
            chk("pop_total",    npop[p],  (p_en[p] != 0 && p_wr[p] != 0) ? p_len[p] + 1 : 0);
            chk("rvalid_total", nrv[p],   (p_en[p] != 0 && p_wr[p] == 0) ? p_len[p] + 1 : 0);
            chk("done_total",   ndone[p], p_en[p]);
        end
        chk("beat_total", nen, exp_en);
        if (nack[0] == p_en[0] && nack[1] == p_en[1] && (p_en[0] + p_en[1]) > 0) begin
            first = (p_en[0] != 0 && p_en[1] != 0) ? rr_pref : ((p_en[0] != 0) ? 0 : 1);
            chk("first_ack_cycle", ackc[first], 0);
            check_burst(first, ackc[first]);
            rr_pref = 1 - first;
            if (p_en[0] != 0 && p_en[1] != 0) begin
                second = 1 - first;
                exp_a  = ackc[first] + p_len[first] + ((p_wr[first] != 0) ? 2 : 4);
                chk("second_ack_cycle", ackc[second], exp_a);
                check_burst(second, ackc[second]);
                rr_pref = 1 - second;
            end
        end
    endtask

    task automatic run_pair(input int en0, input int wr0, input int a0, input int l0,
                            input int en1, input int wr1, input int a1, input int l1,
                            input int budget);
        start_run();
        if (en0 != 0) set_req(0, wr0, a0, l0, -1);
        if (en1 != 0) set_req(1, wr1, a1, l1, -1);
        run_cycles(budget);
        verify_run();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        i_RSTn = 1'b0;
        bus.i_Req0 = 0; bus.i_Req1 = 0; bus.i_Wr0 = 0; bus.i_Wr1 = 0;
        bus.i_Addr0 = '0; bus.i_Addr1 = '0; bus.i_Len0 = '0; bus.i_Len1 = '0;
        bus.i_WData0 = '0; bus.i_WData1 = '0;
        for (int a = 0; a < DEPTH; a++) begin
            sram_mem[a] = DW'(a * 37 + 11);
            ref_mem[a]  = DW'(a * 37 + 11);
        end
        rr_pref = 0;

        // Contention from reset: both requests pending while in reset.
        start_run();
        set_req(0, 1, 'h010, 3, 'hA0);
        set_req(1, 1, 'h100, int'($urandom_range(7, 0)), -1);
        repeat (3) @(negedge CLK);
        check_idle_outputs();
        i_RSTn = 1'b1;
        run_cycles(100);
        verify_run();

        // Readback of 0x010..0x013 on port 0 (expects A0..A3).
        run_pair(1, 0, 'h010, 3, 0, 0, 0, 0, 100);

        // Second tie: port 1 is preferred after port 0's last grant.
        run_pair(1, 0, int'($urandom_range(1023, 0)), int'($urandom_range(7, 0)),
                 1, 0, int'($urandom_range(1023, 0)), int'($urandom_range(7, 0)), 100);

        // Address wrap: write across 0x3FF -> 0x000, then read it back.
        run_pair(0, 0, 0, 0, 1, 1, 'h3FE, 3, 100);
        run_pair(1, 0, 'h3FE, 3, 0, 0, 0, 0, 100);

        // Randomized bursts, sometimes contending.
        for (int n = 0; n < 8; n++) begin
            int e0, e1;
            e0 = int'($urandom_range(1, 0));
            e1 = (e0 != 0) ? int'($urandom_range(1, 0)) : 1;
            run_pair(e0, int'($urandom_range(1, 0)), int'($urandom_range(1023, 0)),
                     int'($urandom_range(15, 0)),
                     e1, int'($urandom_range(1, 0)), int'($urandom_range(1023, 0)),
                     int'($urandom_range(15, 0)), 120);
        end

        // Maximum length: 1024-beat read of the whole array.
        run_pair(1, 0, 0, 1023, 0, 0, 0, 0, 1150);

        // Reset during the second beat of a Len=7 write on port 0.
        start_run();
        set_req(0, 1, 'h200, 7, -1);
        step();
        chk("mid_ack0", lg_ack[0], 2'b01);
        step();
        chk("mid_pop_before_reset", lg_pop[1], 2'b01);
        #1;
        i_RSTn = 1'b0;
        #1;
        check_idle_outputs();
        set_req(1, 0, 'h300, 2, -1);
        step();
        step();
        chk("rst_no_done", {lg_done[2], lg_done[3]}, 0);
        chk("rst_no_pop",  {lg_pop[2], lg_pop[3]}, 0);
        chk("rst_no_ack",  {lg_ack[2], lg_ack[3]}, 0);
        i_RSTn  = 1'b1;
        rr_pref = 0;
        start_run();
        p_en[1] = 1; p_wr[1] = 0; p_addr[1] = 'h300; p_len[1] = 2;
        run_cycles(100);
        verify_run();

        // Later tie after reset: port 0 preferred.
        run_pair(1, int'($urandom_range(1, 0)), int'($urandom_range(1023, 0)),
                 int'($urandom_range(7, 0)),
                 1, int'($urandom_range(1, 0)), int'($urandom_range(1023, 0)),
                 int'($urandom_range(7, 0)), 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
